// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg
//   Shared definitions for the iterative signed divider: operand width,
//   fixed result latency, FSM state encoding, RISC-V special-case
//   constants and a magnitude helper.
package seq_divider_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = 33;
  localparam int DIV_STEPS   = DIV_WIDTH;
  localparam int CNT_W       = $clog2(DIV_STEPS);

  // Quotient returned for a zero divisor (all ones) and the most negative
  // value, which is both the overflow dividend and the overflow quotient.
  localparam logic [DIV_WIDTH-1:0] QUO_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [DIV_WIDTH-1:0] INT_MIN      = 32'h8000_0000;
  localparam logic [DIV_WIDTH-1:0] NEG_ONE      = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Unsigned magnitude of a two's-complement value. INT_MIN maps onto
  // itself, which read as unsigned is exactly 2^31.
  function automatic logic [DIV_WIDTH-1:0] abs_mag(input logic [DIV_WIDTH-1:0] v);
    return v[DIV_WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// seq_div_step
//   One combinational restoring-division step on the {rem, quo} shift pair.
//   Ports:
//     pair_in  - current {rem, quo}; quo still holds unconsumed dividend bits
//     divisor  - unsigned divisor magnitude
//     pair_out - {rem, quo} after shifting in one dividend bit and, if the
//                trial remainder covers the divisor, subtracting it and
//                setting the new quotient bit
module seq_div_step
  import seq_divider_pkg::*;
(
  input  logic [2*DIV_WIDTH-1:0] pair_in,
  input  logic [DIV_WIDTH-1:0]   divisor,
  output logic [2*DIV_WIDTH-1:0] pair_out
);

  // Trial remainder is 33 bits: the shifted remainder can exceed 2^32-1
  // before the subtraction brings it back under the divisor.
  logic [DIV_WIDTH:0] trial;
  logic [DIV_WIDTH:0] diff;

  always_comb begin
    trial = pair_in[2*DIV_WIDTH-1:DIV_WIDTH-1];
    diff  = trial - {1'b0, divisor};
    // diff MSB set means the subtraction borrowed: trial < divisor.
    if (!diff[DIV_WIDTH]) begin
      pair_out = {diff[DIV_WIDTH-1:0], pair_in[DIV_WIDTH-2:0], 1'b1};
    end else begin
      pair_out = {trial[DIV_WIDTH-1:0], pair_in[DIV_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider
//   Iterative signed 32-bit radix-2 restoring divider with RISC-V DIV/REM
//   semantics. Fixed latency: a pair completing at edge E produces a result
//   that is valid in the cycle after edge E+32.
//   Ports:
//     clk, rst_n             - rising-edge clock, async active-low reset
//     s_axis_dividend_tvalid - dividend channel valid
//     s_axis_dividend_tdata  - signed dividend
//     s_axis_divisor_tvalid  - divisor channel valid
//     s_axis_divisor_tdata   - signed divisor
//     m_axis_dout_tvalid     - one-cycle result strobe
//     m_axis_dout_tdata      - {quotient[63:32], remainder[31:0]}, held
//                              until the next result
//
// Handshake: all channels are valid-only (no tready). An input beat is
// consumed on any rising edge where its tvalid is high and the divider is
// in IDLE or DONE; beats during CALC are dropped, and the sender guarantees
// it does not issue then. Each channel keeps one held value that a newer
// beat overwrites. The output strobe is high for exactly one cycle per
// result and the consumer must take the data in that cycle or later from
// the held register.
module seq_divider
  import seq_divider_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_axis_dividend_tvalid,
  input  logic [DIV_WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic                   s_axis_divisor_tvalid,
  input  logic [DIV_WIDTH-1:0]   s_axis_divisor_tdata,
  output logic                   m_axis_dout_tvalid,
  output logic [2*DIV_WIDTH-1:0] m_axis_dout_tdata
);

  state_t state, state_nxt;

  // Capture registers for the two independent input channels.
  logic                 dvd_held, dsr_held;
  logic [DIV_WIDTH-1:0] dvd_hold_q, dsr_hold_q;

  // Working registers for the running division.
  logic [2*DIV_WIDTH-1:0] pair_q;
  logic [DIV_WIDTH-1:0]   dsr_mag_q;
  logic [DIV_WIDTH-1:0]   dvd_orig_q;
  logic                   q_neg_q, r_neg_q;
  logic                   div0_q, ovf_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [2*DIV_WIDTH-1:0] dout_q;

  // Combinational helpers.
  logic                   accept;
  logic                   pair_go;
  logic                   last_step;
  logic [DIV_WIDTH-1:0]   dvd_cur, dsr_cur;
  logic [2*DIV_WIDTH-1:0] step_out;
  logic [DIV_WIDTH-1:0]   raw_quo, raw_rem;
  logic [DIV_WIDTH-1:0]   fix_quo, fix_rem;

  seq_div_step u_step (
    .pair_in  (pair_q),
    .divisor  (dsr_mag_q),
    .pair_out (step_out)
  );

  // A live beat takes priority over the held copy so that a pair can form
  // in the same edge as the second channel's arrival.
  always_comb begin
    accept    = (state != CALC);
    dvd_cur   = s_axis_dividend_tvalid ? s_axis_dividend_tdata : dvd_hold_q;
    dsr_cur   = s_axis_divisor_tvalid  ? s_axis_divisor_tdata  : dsr_hold_q;
    pair_go   = accept
              && (dvd_held || s_axis_dividend_tvalid)
              && (dsr_held || s_axis_divisor_tvalid);
    last_step = (state == CALC) && (cnt_q == CNT_W'(DIV_STEPS - 1));
  end

  // Sign fix-up on the output of the final step, so the result register is
  // loaded on the same edge that enters DONE.
  always_comb begin
    raw_quo = step_out[DIV_WIDTH-1:0];
    raw_rem = step_out[2*DIV_WIDTH-1:DIV_WIDTH];
    fix_quo = q_neg_q ? (~raw_quo + 1'b1) : raw_quo;
    fix_rem = r_neg_q ? (~raw_rem + 1'b1) : raw_rem;
    if (div0_q) begin
      fix_quo = QUO_ALL_ONES;
      fix_rem = dvd_orig_q;
    end else if (ovf_q) begin
      fix_quo = INT_MIN;
      fix_rem = '0;
    end
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pair_go) state_nxt = CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = pair_go ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Input capture: a completed pair consumes both held values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_held   <= 1'b0;
      dsr_held   <= 1'b0;
      dvd_hold_q <= '0;
      dsr_hold_q <= '0;
    end else if (pair_go) begin
      dvd_held <= 1'b0;
      dsr_held <= 1'b0;
    end else if (accept) begin
      if (s_axis_dividend_tvalid) begin
        dvd_held   <= 1'b1;
        dvd_hold_q <= s_axis_dividend_tdata;
      end
      if (s_axis_divisor_tvalid) begin
        dsr_held   <= 1'b1;
        dsr_hold_q <= s_axis_divisor_tdata;
      end
    end
  end

  // Working registers: load magnitudes and flags on pair completion, then
  // step once per CALC cycle. Special cases still run the full 32 steps so
  // latency never depends on the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q     <= '0;
      dsr_mag_q  <= '0;
      dvd_orig_q <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div0_q     <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
    end else if (pair_go) begin
      pair_q     <= {{DIV_WIDTH{1'b0}}, abs_mag(dvd_cur)};
      dsr_mag_q  <= abs_mag(dsr_cur);
      dvd_orig_q <= dvd_cur;
      q_neg_q    <= dvd_cur[DIV_WIDTH-1] ^ dsr_cur[DIV_WIDTH-1];
      r_neg_q    <= dvd_cur[DIV_WIDTH-1];
      div0_q     <= (dsr_cur == '0);
      ovf_q      <= (dvd_cur == INT_MIN) && (dsr_cur == NEG_ONE);
      cnt_q      <= '0;
    end else if (state == CALC) begin
      pair_q <= step_out;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (last_step) begin
      dout_q <= {fix_quo, fix_rem};
    end
  end

  assign m_axis_dout_tvalid = (state == DONE);
  assign m_axis_dout_tdata  = dout_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        dvd_valid;
  logic [31:0] dvd_data;
  logic        dsr_valid;
  logic [31:0] dsr_data;
  logic        dout_valid;
  logic [63:0] dout_data;

  int checks   = 0;
  int failures = 0;

  seq_divider dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .s_axis_dividend_tvalid (dvd_valid),
    .s_axis_dividend_tdata  (dvd_data),
    .s_axis_divisor_tvalid  (dsr_valid),
    .s_axis_divisor_tdata   (dsr_data),
    .m_axis_dout_tvalid     (dout_valid),
    .m_axis_dout_tdata      (dout_data)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: present both operands for one edge (edge E).
  task automatic issue_pair(input logic [31:0] dvd, input logic [31:0] dsr);
    dvd_valid = 1'b1;
    dvd_data  = dvd;
    dsr_valid = 1'b1;
    dsr_data  = dsr;
    tick();
    dvd_valid = 1'b0;
    dsr_valid = 1'b0;
  endtask

  // Count edges until the result strobe is seen, starting from 'already'.
  // Bounded: gives up at 40 and returns that count so the check fails.
  task automatic wait_result(input int already, output int edges);
    edges = already;
    while (edges < 40) begin
      tick();
      edges++;
      if (dout_valid) break;
    end
  endtask

  // Latency, data, single-cycle strobe and hold after the strobe.
  task automatic check_result(input string tag, input int edges, input logic [63:0] exp);
    chk({tag, "_latency"}, 64'(edges), 64'd32);
    chk({tag, "_data"}, dout_data, exp);
    tick();
    chk({tag, "_pulse_low"}, {63'd0, dout_valid}, 64'd0);
    chk({tag, "_hold"}, dout_data, exp);
  endtask

  int edges;
  int pulses;

  initial begin
    rst_n     = 1'b0;
    dvd_valid = 1'b0;
    dvd_data  = '0;
    dsr_valid = 1'b0;
    dsr_data  = '0;
    tick();
    tick();
    chk("reset_tvalid", {63'd0, dout_valid}, 64'd0);
    chk("reset_tdata", dout_data, 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic and signed cases, each with a full latency measurement.
    issue_pair(32'd100, 32'd7);
    wait_result(0, edges);
    check_result("div_100_7", edges, {32'h0000_000E, 32'h0000_0002});

    issue_pair(32'hFFFF_FFF9, 32'd2);
    wait_result(0, edges);
    check_result("div_m7_2", edges, {32'hFFFF_FFFD, 32'hFFFF_FFFF});

    issue_pair(32'd7, 32'hFFFF_FFFE);
    wait_result(0, edges);
    check_result("div_7_m2", edges, {32'hFFFF_FFFD, 32'h0000_0001});

    issue_pair(32'd5, 32'd0);
    wait_result(0, edges);
    check_result("div_by_zero", edges, {32'hFFFF_FFFF, 32'h0000_0005});

    issue_pair(32'h8000_0000, 32'hFFFF_FFFF);
    wait_result(0, edges);
    check_result("overflow", edges, {32'h8000_0000, 32'h0000_0000});

    // Staggered arrival: dividend first, divisor three edges later.
    dvd_valid = 1'b1;
    dvd_data  = 32'd50;
    tick();
    dvd_valid = 1'b0;
    tick();
    tick();
    dsr_valid = 1'b1;
    dsr_data  = 32'd8;
    tick();
    dsr_valid = 1'b0;
    // Stray dividend beat during CALC must be dropped.
    for (int i = 0; i < 5; i++) tick();
    dvd_valid = 1'b1;
    dvd_data  = 32'd99;
    tick();
    dvd_valid = 1'b0;
    wait_result(6, edges);
    chk("stagger_latency", 64'(edges), 64'd32);
    chk("stagger_data", dout_data, {32'd6, 32'd2});

    // In the DONE cycle present only a divisor; the dropped 99 must not
    // have left a held dividend, so nothing may start.
    dsr_valid = 1'b1;
    dsr_data  = 32'd3;
    tick();
    dsr_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dout_valid) pulses++;
    end
    chk("lone_divisor_no_start", 64'(pulses), 64'd0);
    dvd_valid = 1'b1;
    dvd_data  = 32'd21;
    tick();
    dvd_valid = 1'b0;
    wait_result(0, edges);
    chk("held_divisor_latency", 64'(edges), 64'd32);
    chk("held_divisor_data", dout_data, {32'd7, 32'd0});

    // Back-to-back: second pair issued in the DONE cycle of the first.
    tick();
    issue_pair(32'd100, 32'd7);
    wait_result(0, edges);
    chk("b2b_first_data", dout_data, {32'h0000_000E, 32'h0000_0002});
    issue_pair(32'd9, 32'd4);
    chk("b2b_recalc_no_strobe", {63'd0, dout_valid}, 64'd0);
    wait_result(1, edges);
    chk("b2b_latency", 64'(edges), 64'd33);
    chk("b2b_data", dout_data, {32'd2, 32'd1});
    tick();

    // Asynchronous reset at CALC step 10.
    issue_pair(32'd1000, 32'd7);
    for (int i = 0; i < 10; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tvalid", {63'd0, dout_valid}, 64'd0);
    chk("async_rst_tdata", dout_data, 64'd0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dout_valid) pulses++;
    end
    chk("aborted_no_result", 64'(pulses), 64'd0);
    issue_pair(32'd20, 32'd3);
    wait_result(0, edges);
    check_result("after_reset", edges, {32'd6, 32'd2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative signed 32-bit radix-2 divider serving as the responder on the dividend/divisor/result stream interface driven by the execute-stage divide functional unit. It captures a dividend and a divisor on independent valid-only channels, runs a fixed-latency restoring division, and returns a single-cycle-valid 64-bit {quotient, remainder} word. RISC-V DIV/REM semantics apply, including divide-by-zero and overflow.

## Interface
- WIDTH, 32, operand width; the result is 2*WIDTH wide.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_dividend_tvalid  in  1  dividend channel valid.
- s_axis_dividend_tdata  in  32  signed dividend.
- s_axis_divisor_tvalid  in  1  divisor channel valid.
- s_axis_divisor_tdata  in  32  signed divisor.
- m_axis_dout_tvalid  out  1  result valid, single-cycle pulse.
- m_axis_dout_tdata  out  64  [63:32] signed quotient, [31:0] signed remainder.

## Operation
- Protocol has no tready; the sender never issues while the divider is in CALC.
- States: IDLE, CALC, DONE.
- Operands are accepted only in IDLE or DONE.
  - A tvalid in either state latches that channel's data and sets its held flag.
  - A repeat tvalid on an already-held channel overwrites the held value.
- Pair complete: at the edge where both channels are held or valid, the block:
  - loads |dividend| and |divisor| into the working registers;
  - records the quotient sign (signs differ) and remainder sign (dividend sign);
  - records the flags div_by_zero and overflow (dividend 0x80000000 and divisor 0xFFFFFFFF);
  - clears both held flags, zeroes the step counter, and enters CALC.
- CALC: performs one restoring step per cycle on a 64-bit {rem, quo} shift pair, using unsigned magnitudes (0x80000000 is treated as 2^31). After 32 steps it goes to DONE.
- Entry to DONE: m_axis_dout_tdata is registered from the fix-up logic:
  - div_by_zero: quotient 0xFFFFFFFF, remainder = original dividend.
  - overflow: quotient 0x80000000, remainder 0.
  - otherwise: quotient and remainder are negated per their recorded signs.
- DONE: m_axis_dout_tvalid = 1 for exactly this cycle. The next state is CALC if a pair completes this cycle, else IDLE.
- m_axis_dout_tdata holds its last value until the next DONE entry.
- tvalid seen during CALC is ignored: no latch and no held-flag change.

## Timing
- Reset (asynchronous, rst_n low):
  - state IDLE, held flags 0, counter 0, working registers 0;
  - m_axis_dout_tvalid 0, m_axis_dout_tdata 0.
- Reset mid-CALC aborts the operation; no result is produced.
- Latency is fixed and independent of operand values or special cases. If a pair completes at edge E, m_axis_dout_tvalid is high in the cycle following edge E+32, i.e. it is sampled high at edge E+33.
- Maximum throughput is back-to-back issue in the DONE cycle, giving one result every 33 cycles.
- Staggered arrival: edge E is the edge at which the second channel's tvalid is sampled.

## Structure
- Package seq_divider_pkg:
  - state enum {IDLE, CALC, DONE};
  - DIV_WIDTH = 32;
  - DIV_LATENCY = 33;
  - special-case constants 0xFFFFFFFF and 0x80000000.
- Natural sub-module: seq_div_step, a combinational single restoring step. Inputs are the {rem, quo} pair and the divisor magnitude; outputs are the next pair.
- The top level holds the FSM, the capture registers, the counter, and the sign fix-up.

## Test plan
- 100 / 7, both valid at edge E → tvalid sampled at E+33 only; tdata = {0x0000000E, 0x00000002}.
- −7 / 2 → {0xFFFFFFFD, 0xFFFFFFFF}; 7 / −2 → {0xFFFFFFFD, 0x00000001}.
- 5 / 0 → {0xFFFFFFFF, 0x00000005}; 0x80000000 / 0xFFFFFFFF → {0x80000000, 0x00000000}; both at latency 33.
- Dividend 50 at edge E, divisor 8 at edge E+3 → tvalid at E+36 with {6, 2}. A tvalid of 99 during CALC leaves the following result unaffected.
- Back-to-back: the second pair 9 / 4 is issued in the DONE cycle of the first. The result {2, 1} arrives exactly 33 edges after that DONE edge.
- rst_n low asynchronously at CALC step 10:
  - outputs are 0 immediately;
  - no tvalid pulse follows;
  - a new 20 / 3 then completes normally with {6, 2}.
